// File: rtl/shared_adder_sequencer.sv
// rtl/shared_adder_sequencer.sv - round-robin sequencer sharing one external 16-bit adder
//
// Purpose: grants one of NREQ requesters at a time (round robin), runs its
// addition through an external combinational 16-bit adder in one pass
// (narrow) or two chained passes (wide), and holds the result until taken.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/wide/cin    per-requester request valid, 32-bit select, carry-in
//   req_a, req_b          packed 32-bit operands, requester i at [32i+31:32i]
//   req_ready             one-hot acceptance pulse (IDLE only)
//   busy                  high whenever the FSM is not IDLE
//   add_x/add_y/add_c0    operands to the external adder
//   add_sum/add_c16       result from the external adder
//   resp_valid/resp_ready result handshake
//   resp_id/sum/cout      requester id, 32-bit result, final carry-out

module shared_adder_sequencer #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_wide,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 busy,
  output logic [15:0]          add_x,
  output logic [15:0]          add_y,
  output logic                 add_c0,
  input  logic [15:0]          add_sum,
  input  logic                 add_c16,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_sum,
  output logic                 resp_cout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC_LO = 2'd1,
    S_EXEC_HI = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [IDW-1:0] r_ptr;
  logic [31:0]    r_a;
  logic [31:0]    r_b;
  logic           r_cin;
  logic           r_wide;
  logic [IDW-1:0] r_id;
  logic [15:0]    r_sum_lo;
  logic [15:0]    r_sum_hi;
  logic           r_carry;

  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic [IDW-1:0] w_cand;
  logic [31:0]    w_sel_a;
  logic [31:0]    w_sel_b;
  logic           w_sel_cin;
  logic           w_sel_wide;

  // Round-robin search: first valid requester at or above r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_cin  = 1'b0;
    w_sel_wide = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_sel_a    = req_a[32*i +: 32];
        w_sel_b    = req_b[32*i +: 32];
        w_sel_cin  = req_cin[i];
        w_sel_wide = req_wide[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = '0;
    add_x      = 16'h0000;
    add_y      = 16'h0000;
    add_c0     = 1'b0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_sum   = 32'h0000_0000;
    resp_cout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_grant] = 1'b1;
          w_next             = S_EXEC_LO;
        end
      end
      S_EXEC_LO: begin
        add_x  = r_a[15:0];
        add_y  = r_b[15:0];
        add_c0 = r_cin;
        w_next = r_wide ? S_EXEC_HI : S_RESP;
      end
      S_EXEC_HI: begin
        add_x  = r_a[31:16];
        add_y  = r_b[31:16];
        add_c0 = r_carry;
        w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_id    = r_id;
        // r_sum_hi may be stale from an earlier wide op; narrow results mask it.
        resp_sum   = r_wide ? {r_sum_hi, r_sum_lo} : {16'h0000, r_sum_lo};
        resp_cout  = r_carry;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_wide   <= 1'b0;
      r_id     <= '0;
      r_sum_lo <= '0;
      r_sum_hi <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_cin  <= w_sel_cin;
            r_wide <= w_sel_wide;
            r_id   <= w_grant;
            r_ptr  <= (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
          end
        end
        S_EXEC_LO: begin
          r_sum_lo <= add_sum;
          r_carry  <= add_c16;
        end
        S_EXEC_HI: begin
          r_sum_hi <= add_sum;
          r_carry  <= add_c16;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_sequencer.sv
// tb/tb_shared_adder_sequencer.sv - self-checking bench for shared_adder_sequencer
module tb_shared_adder_sequencer;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid, req_wide, req_cin, req_ready;
  logic [NREQ*32-1:0]  req_a, req_b;
  logic                busy;
  logic [15:0]         add_x, add_y, add_sum;
  logic                add_c0, add_c16;
  logic                resp_valid, resp_ready, resp_cout;
  logic [IDW-1:0]      resp_id;
  logic [31:0]         resp_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External combinational adder.
  assign {add_c16, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {16'h0000, add_c0};

  shared_adder_sequencer #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wide(req_wide),
    .req_cin(req_cin), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .busy(busy), .add_x(add_x), .add_y(add_y), .add_c0(add_c0),
    .add_sum(add_sum), .add_c16(add_c16), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_cout(resp_cout)
  );

  // Reference result: {cout, sum32}.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic wide);
    logic [16:0] t;
    if (wide) return {1'b0, a} + {1'b0, b} + {32'h0, cin};
    t = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'h0, cin};
    return {t[16], 16'h0000, t[15:0]};
  endfunction

  task automatic clear_inputs();
    req_valid  = '0;
    req_wide   = '0;
    req_cin    = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one op from a single requester and reports what was observed.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic wide,
                       output int lat, output logic [31:0] sum, output logic cout,
                       output logic [IDW-1:0] rid, output logic c0_lo, output logic c0_hi,
                       output logic [15:0] x_lo, output logic [15:0] x_hi, output bit ok);
    bit acc;
    ok = 0; lat = 0; sum = '0; cout = 0; rid = '0;
    c0_lo = 0; c0_hi = 0; x_lo = '0; x_hi = '0; acc = 0;
    @(negedge clk);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_cin[id]  = cin;
    req_wide[id] = wide;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    resp_ready    = 1'b1;
    for (int w = 0; w < 20; w++) begin
      if (w > 0) @(negedge clk);
      #1;
      if (req_ready[id]) begin acc = 1; break; end
    end
    if (!acc) begin req_valid = '0; return; end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = '0;
      #1;
      if (n == 1) begin c0_lo = add_c0; x_lo = add_x; end
      if (n == 2) begin c0_hi = add_c0; x_hi = add_x; end
      if (resp_valid) begin
        lat = n; sum = resp_sum; cout = resp_cout; rid = resp_id; ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset(2);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_sum !== 32'h0 || resp_cout !== 1'b0 || resp_id !== '0)
      begin errors++; $display("FAIL reset_resp: got v=%b sum=%h c=%b id=%0d required all 0", resp_valid, resp_sum, resp_cout, resp_id); end
    checks++;
    if (req_ready !== '0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: got ready=%b busy=%b required 0", req_ready, busy); end
    checks++;
    if (add_x !== 16'h0 || add_y !== 16'h0 || add_c0 !== 1'b0)
      begin errors++; $display("FAIL reset_adder: got x=%h y=%h c0=%b required 0", add_x, add_y, add_c0); end
  endtask

  task automatic test_narrow();
    int lat; logic [31:0] s; logic c, c0l, c0h; logic [IDW-1:0] id; logic [15:0] xl, xh; bit ok;
    do_op(0, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, lat, s, c, id, c0l, c0h, xl, xh, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL narrow_timeout: got no response required one"); return; end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL narrow_latency: got %0d required 2", lat); end
    checks++;
    if (s !== 32'h0000_5555 || c !== 1'b0 || id !== 2'd0)
      begin errors++; $display("FAIL narrow_result: got sum=%h c=%b id=%0d required 00005555 0 0", s, c, id); end
    checks++;
    if (xl !== 16'h1234 || c0l !== 1'b0)
      begin errors++; $display("FAIL narrow_lo_pass: got x=%h c0=%b required 1234 0", xl, c0l); end
  endtask

  task automatic test_wide_carry();
    int lat; logic [31:0] s; logic c, c0l, c0h; logic [IDW-1:0] id; logic [15:0] xl, xh; bit ok;
    do_op(2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, lat, s, c, id, c0l, c0h, xl, xh, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wide_timeout: got no response required one"); return; end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL wide_latency: got %0d required 3", lat); end
    checks++;
    if (c0l !== 1'b0 || c0h !== 1'b1 || xh !== 16'h0000)
      begin errors++; $display("FAIL wide_chain: got c0_lo=%b c0_hi=%b x_hi=%h required 0 1 0000", c0l, c0h, xh); end
    checks++;
    if (s !== 32'h0001_0000 || c !== 1'b0 || id !== 2'd2)
      begin errors++; $display("FAIL wide_result: got sum=%h c=%b id=%0d required 00010000 0 2", s, c, id); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] s; logic c, c0l, c0h; logic [IDW-1:0] id; logic [15:0] xl, xh; bit ok;
    do_op(3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, lat, s, c, id, c0l, c0h, xl, xh, ok);
    checks++;
    if (!ok || s !== 32'h0 || c !== 1'b1 || id !== 2'd3 || lat != 3)
      begin errors++; $display("FAIL wrap_result: got ok=%0d sum=%h c=%b id=%0d lat=%0d required 1 00000000 1 3 3", ok, s, c, id, lat); end
  endtask

  task automatic test_random_ops();
    int lat; logic [31:0] s, a, b; logic c, c0l, c0h, cin, wide; logic [IDW-1:0] id;
    logic [15:0] xl, xh; bit ok; int r; logic [32:0] e;
    for (int it = 0; it < 16; it++) begin
      r = int'($urandom_range(0, NREQ - 1));
      a = $urandom; b = $urandom; cin = 1'($urandom); wide = 1'($urandom);
      e = ref_add(a, b, cin, wide);
      do_op(r, a, b, cin, wide, lat, s, c, id, c0l, c0h, xl, xh, ok);
      checks++;
      if (!ok || s !== e[31:0] || c !== e[32] || id !== IDW'(r) || lat != (wide ? 3 : 2))
        begin errors++; $display("FAIL rand_op%0d: got ok=%0d sum=%h c=%b id=%0d lat=%0d required sum=%h c=%b id=%0d", it, ok, s, c, id, lat, e[31:0], e[32], r); end
    end
  endtask

  task automatic test_round_robin();
    int gid[$]; int gcyc[$]; int mptr; int g;
    clear_inputs();
    do_reset(1);
    @(negedge clk);
    req_valid = '1;
    for (int cyc = 0; cyc < 40 && gid.size() < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (req_ready != '0) begin
        checks++;
        if (!$onehot(req_ready) || busy)
          begin errors++; $display("FAIL rr_pulse: got ready=%b busy=%b required one-hot while idle", req_ready, busy); end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin gid.push_back(i); gcyc.push_back(cyc); end
      end
    end
    req_valid = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (gid.size() != 5) begin errors++; $display("FAIL rr_count: got %0d grants required 5", gid.size()); return; end
    mptr = 0;
    for (int k = 0; k < 5; k++) begin
      g = mptr;  // all requesters valid: the pointer itself wins
      mptr = (g + 1) % NREQ;
      checks++;
      if (gid[k] != g) begin errors++; $display("FAIL rr_order%0d: got %0d required %0d", k, gid[k], g); end
      if (k > 0) begin
        checks++;
        if (gcyc[k] - gcyc[k-1] != 3)
          begin errors++; $display("FAIL rr_spacing%0d: got %0d cycles required 3", k, gcyc[k] - gcyc[k-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, hs; logic [32:0] e; bit seen; logic hc; logic [IDW-1:0] hid;
    clear_inputs();
    a = $urandom; b = $urandom;
    e = ref_add(a, b, 1'b0, 1'b0);
    @(negedge clk);
    req_a[63:32] = a; req_b[63:32] = b;
    req_valid = 4'b0010; resp_ready = 1'b0;
    seen = 0;
    for (int w = 0; w < 20; w++) begin
      if (w > 0) @(negedge clk);
      #1;
      if (req_ready[1]) begin seen = 1; break; end
    end
    @(negedge clk);
    req_valid = 4'b0001;  // another requester waits throughout the stall
    seen = 0;
    for (int w = 0; w < 10; w++) begin
      #1;
      if (resp_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_timeout: got no response required one"); req_valid = '0; resp_ready = 1'b1; return; end
    hs = resp_sum; hc = resp_cout; hid = resp_id;
    checks++;
    if (hs !== e[31:0] || hc !== e[32] || hid !== 2'd1)
      begin errors++; $display("FAIL bp_result: got sum=%h c=%b id=%0d required %h %b 1", hs, hc, hid, e[31:0], e[32]); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_sum !== hs || resp_cout !== hc || resp_id !== hid || req_ready !== '0 || busy !== 1'b1)
        begin errors++; $display("FAIL bp_hold%0d: got v=%b sum=%h ready=%b busy=%b required held result, no grant, busy", k, resp_valid, resp_sum, req_ready, busy); end
    end
    @(negedge clk);
    resp_ready = 1'b1; req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_release: got v=%b busy=%b required 0 0", resp_valid, busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b; bit seen; logic [32:0] e;
    clear_inputs();
    a = $urandom; b = $urandom;
    @(negedge clk);
    req_a[95:64] = a; req_b[95:64] = b; req_wide[2] = 1'b1;
    req_valid = 4'b0100;
    seen = 0;
    for (int w = 0; w < 20; w++) begin
      if (w > 0) @(negedge clk);
      #1;
      if (req_ready[2]) begin seen = 1; break; end
    end
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (!seen || busy !== 1'b1 || add_x !== a[31:16])
      begin errors++; $display("FAIL mid_exec_hi: got busy=%b x=%h required 1 %h", busy, add_x, a[31:16]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 0 || resp_sum !== 0 || resp_id !== 0 || resp_cout !== 0 || req_ready !== 0 || busy !== 0 || add_x !== 0 || add_y !== 0 || add_c0 !== 0)
      begin errors++; $display("FAIL mid_reset_outputs: got v=%b sum=%h busy=%b x=%h required all 0", resp_valid, resp_sum, busy, add_x); end
    seen = 0;
    repeat (4) begin @(negedge clk); #1; if (resp_valid) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_no_resp: got resp_valid=1 required 0"); end
    // With the pointer back at 0, requester 1 beats requester 3.
    @(negedge clk);
    req_a[63:32] = a; req_b[63:32] = b; req_wide = '0;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr: got ready=%b required 0010", req_ready); end
    @(negedge clk); req_valid = '0;
    e = ref_add(a, b, 1'b0, 1'b0);
    seen = 0;
    for (int w = 0; w < 10; w++) begin
      #1;
      if (resp_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen || resp_sum !== e[31:0] || resp_cout !== e[32] || resp_id !== 2'd1)
      begin errors++; $display("FAIL mid_follow_op: got seen=%0d sum=%h id=%0d required %h 1", seen, resp_sum, resp_id, e[31:0]); end
    @(negedge clk);
  endtask

  typedef struct { logic [IDW-1:0] id; logic [32:0] res; } exp_t;

  task automatic test_random_rr();
    exp_t q[$]; exp_t x;
    logic [31:0] pa [NREQ]; logic [31:0] pb [NREQ]; logic pcin [NREQ]; logic pwide [NREQ];
    logic [NREQ-1:0] pend; int mptr; int expg; bit found; int cyc;
    clear_inputs();
    do_reset(1);
    pend = '0; mptr = 0;
    for (cyc = 0; cyc < 500; cyc++) begin
      if (cyc >= 300 && pend == '0 && q.size() == 0 && !busy) break;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (cyc < 300 && !pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = $urandom; pb[i] = $urandom; pcin[i] = 1'($urandom); pwide[i] = 1'($urandom);
          req_a[32*i +: 32] = pa[i]; req_b[32*i +: 32] = pb[i];
          req_cin[i] = pcin[i]; req_wide[i] = pwide[i];
        end
      end
      req_valid  = pend;
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      found = 0; expg = 0;
      for (int k = 0; k < NREQ; k++)
        if (!found && pend[(mptr + k) % NREQ]) begin found = 1; expg = (mptr + k) % NREQ; end
      if (req_ready != '0) begin
        checks++;
        if (!found || !$onehot(req_ready) || busy || !req_ready[expg])
          begin errors++; $display("FAIL rr_rand_grant: got ready=%b busy=%b required grant %0d", req_ready, busy, expg); end
        if (found) begin
          x.id = IDW'(expg);
          x.res = ref_add(pa[expg], pb[expg], pcin[expg], pwide[expg]);
          q.push_back(x);
          pend[expg] = 1'b0;
          mptr = (expg + 1) % NREQ;
        end
      end else if (!busy && found) begin
        checks++; errors++;
        $display("FAIL rr_rand_idle: got no grant with pending=%b required grant %0d", pend, expg);
      end
      if (resp_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rr_rand_spurious: got response id=%0d required none", resp_id);
        end else if (resp_id !== q[0].id || resp_sum !== q[0].res[31:0] || resp_cout !== q[0].res[32]) begin
          errors++; $display("FAIL rr_rand_resp: got id=%0d sum=%h c=%b required id=%0d sum=%h c=%b", resp_id, resp_sum, resp_cout, q[0].id, q[0].res[31:0], q[0].res[32]);
        end
        if (resp_ready && q.size() != 0) void'(q.pop_front());
      end
    end
    checks++;
    if (pend != '0 || q.size() != 0)
      begin errors++; $display("FAIL rr_rand_drain: got pending=%b outstanding=%0d required 0 0", pend, q.size()); end
    req_valid = '0; resp_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_narrow();
    test_wide_carry();
    test_wrap();
    test_random_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random_rr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
